// File: rtl/ram_test_seq.sv
// ram_test_seq
// Write-then-read-back test sequencer for an external byte-wide asynchronous RAM.
// Each pass writes a pattern byte to every address. It then reads every address
// back. For each read it presents the expected byte alongside the RAM read data,
// then pulses wr_err_reg_out once so the downstream checker accumulates that
// byte's mismatching-bit count.
//
// Ports
//   clk_in, n_rst_in           clock, synchronous active-low reset
//   start_in, abort_in         run control from the SPI block
//   loop_in, pattern_sel_in    run options, latched at start
//   ram_addr_out, ram_data_out, ram_data_oe_out
//                              RAM address, write data, bus drive enable
//   ram_cs_n_out, ram_we_n_out, ram_oe_n_out
//                              RAM strobes, active-low
//   expected_out               expected byte for the checker
//   wr_err_reg_out             accumulate strobe for the checker
//   busy_out, done_out         run status
//   pass_cnt_out               completed passes since start
module ram_test_seq #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk_in,
    input  logic              n_rst_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              loop_in,
    input  logic [1:0]        pattern_sel_in,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [7:0]        ram_data_out,
    output logic              ram_data_oe_out,
    output logic              ram_cs_n_out,
    output logic              ram_we_n_out,
    output logic              ram_oe_n_out,
    output logic [7:0]        expected_out,
    output logic              wr_err_reg_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [7:0]        pass_cnt_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SET,
        S_W_STB,
        S_W_HOLD,
        S_R_SET,
        S_R_STB,
        S_R_HOLD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    // The wait counter is loaded with WAIT_CYC-1 and the phase ends when it reads 0.
    localparam logic [3:0]        CNT_INIT  = 4'(WAIT_CYC - 1);

    // Pattern byte for an address; inv flips every bit on odd passes.
    function automatic logic [7:0] pattern_f(input logic [ADDR_W-1:0] a,
                                             input logic [1:0]        sel,
                                             input logic              inv);
        logic [7:0] base;
        case (sel)
            2'd0:    base = a[0] ? 8'hAA : 8'h55;
            2'd1:    base = 8'(a);
            2'd2:    base = 8'h00;
            default: base = 8'hFF;
        endcase
        return base ^ {8{inv}};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        pass_q, pass_d;
    logic              loop_q, loop_d;
    logic [1:0]        sel_q, sel_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        exp_q, exp_d;
    logic              data_oe_q, data_oe_d;
    logic              cs_n_q, cs_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_phase, rd_phase;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        loop_d  = loop_q;
        sel_d   = sel_q;
        done_d  = done_q;

        if (state_q != S_IDLE && abort_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in && !abort_in) begin
                        state_d = S_W_SET;
                        addr_d  = '0;
                        pass_d  = '0;
                        done_d  = 1'b0;
                        loop_d  = loop_in;
                        sel_d   = pattern_sel_in;
                    end
                end
                S_W_SET: begin
                    state_d = S_W_STB;
                    cnt_d   = CNT_INIT;
                end
                S_W_STB: begin
                    if (cnt_q == '0) state_d = S_W_HOLD;
                    else             cnt_d   = cnt_q - 4'd1;
                end
                S_W_HOLD: begin
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = '0;
                        state_d = S_R_SET;
                        cnt_d   = CNT_INIT;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_W_SET;
                    end
                end
                S_R_SET: begin
                    if (cnt_q == '0) state_d = S_R_STB;
                    else             cnt_d   = cnt_q - 4'd1;
                end
                S_R_STB: begin
                    state_d = S_R_HOLD;
                end
                S_R_HOLD: begin
                    if (addr_q == ADDR_LAST) begin
                        pass_d  = pass_q + 8'd1;
                        addr_d  = '0;
                        state_d = loop_q ? S_W_SET : S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_R_SET;
                        cnt_d   = CNT_INIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        wr_phase  = (state_d == S_W_SET) || (state_d == S_W_STB) || (state_d == S_W_HOLD);
        rd_phase  = (state_d == S_R_SET) || (state_d == S_R_STB) || (state_d == S_R_HOLD);
        if (state_d == S_DONE) done_d = 1'b1;
        busy_d    = wr_phase || rd_phase;
        cs_n_d    = !(wr_phase || rd_phase);
        we_n_d    = (state_d != S_W_STB);
        oe_n_d    = !rd_phase;
        data_oe_d = wr_phase;
        wr_err_d  = (state_d == S_R_STB);
        // Data and expected bytes hold outside their phase so checker inputs
        // never move on the cycle after the strobe, even when aborted.
        data_d    = wr_phase ? pattern_f(addr_d, sel_d, pass_d[0]) : data_q;
        exp_d     = rd_phase ? pattern_f(addr_d, sel_d, pass_d[0]) : exp_q;
    end

    always_ff @(posedge clk_in) begin
        if (!n_rst_in) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            pass_q    <= '0;
            loop_q    <= 1'b0;
            sel_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            exp_q     <= '0;
            data_oe_q <= 1'b0;
            cs_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            loop_q    <= loop_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            exp_q     <= exp_d;
            data_oe_q <= data_oe_d;
            cs_n_q    <= cs_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign ram_addr_out    = addr_q;
    assign ram_data_out    = data_q;
    assign ram_data_oe_out = data_oe_q;
    assign ram_cs_n_out    = cs_n_q;
    assign ram_we_n_out    = we_n_q;
    assign ram_oe_n_out    = oe_n_q;
    assign expected_out    = exp_q;
    assign wr_err_reg_out  = wr_err_q;
    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign pass_cnt_out    = pass_q;

endmodule

// File: tb/tb_ram_test_seq.sv
// Bench for ram_test_seq: a 4-address instance with one-cycle RAM access and a
// second 4-address instance with three-cycle access. The first has a byte-wide
// RAM model with optional stuck-at-0 bits and a mismatch-counting checker.
module tb_ram_test_seq;

    localparam int AW = 2;
    localparam int WA = 1;
    localparam int WB = 3;
    localparam int PASS_CYC = (1 << AW) * 2 * (WA + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_rst = 1'b0;
    logic          start = 1'b0, abort = 1'b0, loop_i = 1'b0;
    logic [1:0]    sel_i = 2'd0;
    logic [AW-1:0] addr_a;
    logic [7:0]    data_a, exp_a, pcnt_a;
    logic          doe_a, cs_a, we_a, oen_a, wrerr_a, busy_a, done_a;

    logic          start_b = 1'b0, abort_b = 1'b0, loop_b = 1'b0;
    logic [1:0]    sel_b = 2'd2;
    logic [AW-1:0] addr_b;
    logic [7:0]    data_b, exp_b, pcnt_b;
    logic          doe_b, cs_b, we_b, oen_b, wrerr_b, busy_b, done_b;

    ram_test_seq #(.ADDR_W(AW), .WAIT_CYC(WA)) dut (
        .clk_in(clk), .n_rst_in(n_rst), .start_in(start), .abort_in(abort),
        .loop_in(loop_i), .pattern_sel_in(sel_i), .ram_addr_out(addr_a),
        .ram_data_out(data_a), .ram_data_oe_out(doe_a), .ram_cs_n_out(cs_a),
        .ram_we_n_out(we_a), .ram_oe_n_out(oen_a), .expected_out(exp_a),
        .wr_err_reg_out(wrerr_a), .busy_out(busy_a), .done_out(done_a),
        .pass_cnt_out(pcnt_a)
    );

    ram_test_seq #(.ADDR_W(AW), .WAIT_CYC(WB)) dut_b (
        .clk_in(clk), .n_rst_in(n_rst), .start_in(start_b), .abort_in(abort_b),
        .loop_in(loop_b), .pattern_sel_in(sel_b), .ram_addr_out(addr_b),
        .ram_data_out(data_b), .ram_data_oe_out(doe_b), .ram_cs_n_out(cs_b),
        .ram_we_n_out(we_b), .ram_oe_n_out(oen_b), .expected_out(exp_b),
        .wr_err_reg_out(wrerr_b), .busy_out(busy_b), .done_out(done_b),
        .pass_cnt_out(pcnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference pattern straight from the pattern rules.
    function automatic logic [7:0] ref_pat(input int a, input int sel, input int pass);
        logic [7:0] b;
        case (sel)
            0:       b = (a % 2 == 1) ? 8'hAA : 8'h55;
            1:       b = 8'(a);
            2:       b = 8'h00;
            default: b = 8'hFF;
        endcase
        return (pass % 2 == 1) ? ~b : b;
    endfunction

    // RAM model, checker model and observed transaction logs for dut
    logic [7:0]    ram [4];
    logic [7:0]    stuck_mask = 8'h00;
    logic [7:0]    wq[$];
    logic [7:0]    rq[$];
    int            we_w = 0, busy_cnt = 0, err_cnt = 0;
    logic          prev_wrerr = 1'b0, post_chk = 1'b0;
    logic [7:0]    prev_exp = 8'h00, pulse_exp = 8'h00;
    logic [AW-1:0] pulse_addr = '0;

    always @(negedge clk) begin
        if (busy_a === 1'b1) busy_cnt++;
        if (we_a === 1'b0) begin
            we_w++;
            check_eq("we_cs_n", cs_a, 0);
            check_eq("we_data_oe", doe_a, 1);
        end else if (we_w > 0) begin
            check_eq("we_width", we_w, WA);
            wq.push_back(data_a);
            ram[addr_a] = data_a;
            we_w = 0;
        end
        if (post_chk) begin
            check_eq("strobe_width", wrerr_a, 0);
            check_eq("exp_after", exp_a, pulse_exp);
            check_eq("addr_after", addr_a, pulse_addr);
            post_chk = 1'b0;
        end
        if (wrerr_a === 1'b1 && prev_wrerr !== 1'b1) begin
            check_eq("exp_before", exp_a, prev_exp);
            check_eq("strobe_oe_n", oen_a, 0);
            rq.push_back(exp_a);
            err_cnt += $countones((ram[addr_a] & ~stuck_mask) ^ exp_a);
            pulse_exp  = exp_a;
            pulse_addr = addr_a;
            post_chk   = 1'b1;
        end
        prev_wrerr = wrerr_a;
        prev_exp   = exp_a;
    end

    // Access timing monitor for dut_b
    int   wb_w = 0, b_run = 0, b_pulses = 0;
    logic b_first = 1'b1;

    always @(negedge clk) begin
        if (we_b === 1'b0) begin
            wb_w++;
        end else if (wb_w > 0) begin
            check_eq("B_we_width", wb_w, WB);
            wb_w = 0;
        end
        if (oen_b !== 1'b0) begin
            b_first = 1'b1;
            b_run   = 0;
        end else if (wrerr_b !== 1'b1) begin
            b_run++;
        end else begin
            check_eq("B_rset_len", b_run, b_first ? WB : WB + 1);
            b_run    = 0;
            b_first  = 1'b0;
            b_pulses++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_once(input int sel, input logic [7:0] mask);
        int n;
        int exp_err;
        tick();
        wq.delete(); rq.delete();
        busy_cnt = 0; err_cnt = 0; stuck_mask = mask;
        loop_i = 1'b0; sel_i = 2'(sel); start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", busy_a, 1);
        check_eq("start_cs_n", cs_a, 0);
        check_eq("start_addr", addr_a, 0);
        check_eq("start_we_n", we_a, 1);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin tick(); n++; end
        check_eq("done_seen", done_a, 1);
        check_eq("busy_cycles", busy_cnt, PASS_CYC);
        check_eq("done_busy", busy_a, 0);
        check_eq("done_pcnt", pcnt_a, 1);
        check_eq("wr_count", wq.size(), 4);
        check_eq("rd_count", rq.size(), 4);
        exp_err = 0;
        for (int a = 0; a < 4; a++) begin
            if (a < wq.size()) check_eq("wr_data", wq[a], ref_pat(a, sel, 0));
            if (a < rq.size()) check_eq("rd_exp", rq[a], ref_pat(a, sel, 0));
            exp_err += $countones(ref_pat(a, sel, 0) & mask);
        end
        check_eq("err_count", err_cnt, exp_err);
        tick();
        check_eq("idle_done_held", done_a, 1);
        check_eq("idle_cs_n", cs_a, 1);
        check_eq("idle_busy", busy_a, 0);
    endtask

    initial begin
        int n;
        int lsel;
        tick(); tick();
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_cs_n", cs_a, 1);
        check_eq("rst_we_n", we_a, 1);
        check_eq("rst_oe_n", oen_a, 1);
        check_eq("rst_wrerr", wrerr_a, 0);
        check_eq("rst_pcnt", pcnt_a, 0);
        n_rst = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;

        run_once(0, 8'h00);
        run_once(0, 8'h01);
        for (int i = 0; i < 4; i++)
            run_once(int'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

        check_eq("B_done", done_b, 1);
        check_eq("B_pulses", b_pulses, 4);

        // Continuous mode, start held through the first pass boundary, then abort.
        lsel = int'($urandom_range(0, 3));
        tick();
        wq.delete(); rq.delete(); stuck_mask = 8'h00;
        loop_i = 1'b1; sel_i = 2'(lsel); start = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_eq("hold_start_pcnt", pcnt_a, 1);
        check_eq("hold_start_busy", busy_a, 1);
        start = 1'b0; loop_i = 1'b0;
        n = 0;
        while (pcnt_a !== 8'd3 && n < 300) begin tick(); n++; end
        check_eq("loop_pcnt3", pcnt_a, 3);
        for (int i = 0; i < int'($urandom_range(0, 15)); i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", busy_a, 0);
        check_eq("abort_done", done_a, 0);
        check_eq("abort_pcnt", pcnt_a, 3);
        check_eq("abort_cs_n", cs_a, 1);
        check_eq("abort_we_n", we_a, 1);
        check_eq("abort_oe_n", oen_a, 1);
        check_eq("abort_wrerr", wrerr_a, 0);
        check_eq("abort_data_oe", doe_a, 0);
        check_eq("loop_wr_count_min", (wq.size() >= 12) ? 1 : 0, 1);
        for (int i = 0; i < 12; i++)
            if (i < wq.size()) check_eq("loop_wr_data", wq[i], ref_pat(i % 4, lsel, i / 4));

        // Start and abort together in IDLE.
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("both_busy", busy_a, 0);
        check_eq("both_cs_n", cs_a, 1);
        tick();
        check_eq("both_busy_later", busy_a, 0);

        // Reset during the write strobe.
        loop_i = 1'b0; sel_i = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (we_a !== 1'b0 && n < 20) begin tick(); n++; end
        check_eq("rst_mid_we_low", we_a, 0);
        n_rst = 1'b0;
        tick();
        check_eq("rstm_addr", addr_a, 0);
        check_eq("rstm_data", data_a, 0);
        check_eq("rstm_data_oe", doe_a, 0);
        check_eq("rstm_cs_n", cs_a, 1);
        check_eq("rstm_we_n", we_a, 1);
        check_eq("rstm_oe_n", oen_a, 1);
        check_eq("rstm_exp", exp_a, 0);
        check_eq("rstm_wrerr", wrerr_a, 0);
        check_eq("rstm_busy", busy_a, 0);
        check_eq("rstm_done", done_a, 0);
        check_eq("rstm_pcnt", pcnt_a, 0);
        n_rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
